// File: rtl/wb_drain_ctrl.sv
// Write-back drain controller: retires replacement-buffer victim lines to pmem and
// shares the pmem port with cache-miss line fetches under a bounded-starvation arbiter.
module wb_drain_ctrl #(
  parameter int unsigned TAG_W        = 11,
  parameter int unsigned OFFSET_W     = 5,
  parameter int unsigned LINE_W       = 256,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wb_waiting,
  input  logic                        wb_full,
  input  logic [LINE_W-1:0]           wb_line,
  input  logic [TAG_W-1:0]            wb_tag,
  output logic                        wb_inc_cur_ptr,
  input  logic                        fetch_req,
  input  logic [TAG_W+OFFSET_W-1:0]   fetch_addr,
  output logic                        fetch_resp,
  output logic [LINE_W-1:0]           fetch_rdata,
  output logic [TAG_W+OFFSET_W-1:0]   pmem_address,
  output logic [LINE_W-1:0]           pmem_wdata,
  output logic                        pmem_read,
  output logic                        pmem_write,
  input  logic                        pmem_resp,
  input  logic [LINE_W-1:0]           pmem_rdata,
  output logic                        drain_busy,
  output logic [TAG_W-1:0]            drain_tag
);

  localparam int unsigned ADDR_W   = TAG_W + OFFSET_W;
  localparam int unsigned STREAK_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    FETCH  = 2'd2,
    RETIRE = 2'd3
  } state_t;

  state_t              state;
  logic [STREAK_W-1:0] streak;
  logic [LINE_W-1:0]   line_q;
  logic [TAG_W-1:0]    tag_q;
  logic [TAG_W-1:0]    addr_q;

  logic streak_sat;
  logic drain_go;

  // Offset bits of the fetch address never reach pmem; addresses are line-aligned.
  logic unused_offset_bits;
  assign unused_offset_bits = ^fetch_addr[OFFSET_W-1:0];

  assign streak_sat = (streak == STREAK_W'(STARVE_LIMIT));
  // A waiting drain wins when the buffer is full, fetches have starved it, or no fetch competes.
  assign drain_go   = wb_waiting && (wb_full || streak_sat || !fetch_req);

  // Arbitration FSM; the latched line/tag/address are private copies so the buffer may move on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      streak <= '0;
      line_q <= '0;
      tag_q  <= '0;
      addr_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (drain_go) begin
            state  <= DRAIN;
            line_q <= wb_line;
            tag_q  <= wb_tag;
            streak <= '0;
          end else if (fetch_req) begin
            state  <= FETCH;
            addr_q <= fetch_addr[ADDR_W-1:OFFSET_W];
            if (wb_waiting && !streak_sat) begin
              streak <= streak + STREAK_W'(1);
            end
          end
        end
        DRAIN: begin
          if (pmem_resp) begin
            state <= RETIRE;
          end
        end
        FETCH: begin
          if (pmem_resp) begin
            state <= IDLE;
          end
        end
        RETIRE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Moore strobes decoded from the state register; fetch completion passes pmem_resp through.
  always_comb begin
    pmem_read      = 1'b0;
    pmem_write     = 1'b0;
    pmem_address   = '0;
    pmem_wdata     = '0;
    wb_inc_cur_ptr = 1'b0;
    fetch_resp     = 1'b0;
    fetch_rdata    = '0;
    drain_busy     = 1'b0;
    unique case (state)
      DRAIN: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q, OFFSET_W'(0)};
        pmem_wdata   = line_q;
        drain_busy   = 1'b1;
      end
      FETCH: begin
        pmem_read    = 1'b1;
        pmem_address = {addr_q, OFFSET_W'(0)};
        fetch_resp   = pmem_resp;
        if (pmem_resp) begin
          fetch_rdata = pmem_rdata;
        end
      end
      RETIRE: begin
        wb_inc_cur_ptr = 1'b1;
        drain_busy     = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign drain_tag = tag_q;

endmodule

// File: tb/tb_wb_drain_ctrl.sv
// Directed bench for wb_drain_ctrl: drains, fetch arbitration, starvation bound,
// full override, reset mid-drain and back-to-back retirement.
module tb_wb_drain_ctrl;

  localparam int unsigned TAG_W    = 11;
  localparam int unsigned OFFSET_W = 5;
  localparam int unsigned LINE_W   = 256;
  localparam int unsigned ADDR_W   = TAG_W + OFFSET_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              wb_waiting;
  logic              wb_full;
  logic [LINE_W-1:0] wb_line;
  logic [TAG_W-1:0]  wb_tag;
  logic              wb_inc_cur_ptr;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_resp;
  logic [LINE_W-1:0] fetch_rdata;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic              pmem_read;
  logic              pmem_write;
  logic              pmem_resp;
  logic [LINE_W-1:0] pmem_rdata;
  logic              drain_busy;
  logic [TAG_W-1:0]  drain_tag;

  wb_drain_ctrl #(
    .TAG_W(TAG_W), .OFFSET_W(OFFSET_W), .LINE_W(LINE_W), .STARVE_LIMIT(2)
  ) dut (
    .clk(clk), .reset(reset),
    .wb_waiting(wb_waiting), .wb_full(wb_full), .wb_line(wb_line), .wb_tag(wb_tag),
    .wb_inc_cur_ptr(wb_inc_cur_ptr),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_resp(fetch_resp),
    .fetch_rdata(fetch_rdata),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .drain_busy(drain_busy), .drain_tag(drain_tag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int inc_count = 0;
  int inc_last = -100;
  int inc_min_gap = 1000;
  int excl_viol = 0;

  localparam logic [LINE_W-1:0] LA  = {8{32'hDEADBEEF}};
  localparam logic [LINE_W-1:0] LB  = {8{32'h0BADF00D}};
  localparam logic [LINE_W-1:0] LC  = {8{32'h12345678}};
  localparam logic [LINE_W-1:0] LD  = {8{32'hCAFEBABE}};
  localparam logic [LINE_W-1:0] LE  = {8{32'h55AA33CC}};
  localparam logic [LINE_W-1:0] LF  = {8{32'hF00DFACE}};
  localparam logic [LINE_W-1:0] RD1 = {8{32'h11112222}};
  localparam logic [LINE_W-1:0] RD2 = {8{32'h33334444}};
  localparam logic [LINE_W-1:0] RD3 = {8{32'h55556666}};
  localparam logic [LINE_W-1:0] RD4 = {8{32'h77778888}};

  // Pulse bookkeeping and mutual-exclusion watch, sampled mid-cycle.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (wb_inc_cur_ptr) begin
      if (cyc - inc_last < inc_min_gap) inc_min_gap = cyc - inc_last;
      inc_last  = cyc;
      inc_count = inc_count + 1;
    end
    if (pmem_read && pmem_write) excl_viol = excl_viol + 1;
    if (wb_inc_cur_ptr && fetch_resp) excl_viol = excl_viol + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; wb_waiting = 1'b1; wb_full = 1'b1; wb_line = LA; wb_tag = 11'h7FF;
    fetch_req = 1'b1; fetch_addr = 16'hFFFF; pmem_resp = 1'b1; pmem_rdata = '1;
    tick(); tick();
    checks++; if ({pmem_read, pmem_write, wb_inc_cur_ptr, fetch_resp, drain_busy} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes got %b want 00000",
                         {pmem_read, pmem_write, wb_inc_cur_ptr, fetch_resp, drain_busy});
    end
    checks++; if (pmem_address !== 16'h0000) begin
      errors++; $display("FAIL reset_addr got %h want 0000", pmem_address);
    end
    checks++; if (fetch_rdata !== '0 || pmem_wdata !== '0 || drain_tag !== '0) begin
      errors++; $display("FAIL reset_data rdata %h wdata %h tag %h want 0", fetch_rdata, pmem_wdata, drain_tag);
    end
    wb_waiting = 1'b0; wb_full = 1'b0; fetch_req = 1'b0; pmem_resp = 1'b0; pmem_rdata = '0;
    reset = 1'b0;
    tick();
    checks++; if (pmem_write !== 1'b0 || pmem_read !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset got r%b w%b want r0 w0", pmem_read, pmem_write);
    end
  endtask

  task automatic test_single_drain();
    wb_waiting = 1'b1; wb_tag = 11'h12A; wb_line = LA; fetch_req = 1'b0;
    tick();
    checks++; if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 16'h2540) begin
      errors++; $display("FAIL drain_start got w%b r%b addr %h want w1 r0 2540", pmem_write, pmem_read, pmem_address);
    end
    checks++; if (pmem_wdata !== LA || drain_busy !== 1'b1 || drain_tag !== 11'h12A) begin
      errors++; $display("FAIL drain_latch got busy %b tag %h wdata %h", drain_busy, drain_tag, pmem_wdata);
    end
    wb_tag = 11'h055; wb_line = LB;
    tick();
    checks++; if (pmem_address !== 16'h2540 || pmem_wdata !== LA) begin
      errors++; $display("FAIL drain_stable got addr %h wdata %h want 2540 and first line", pmem_address, pmem_wdata);
    end
    tick();
    checks++; if (pmem_write !== 1'b1 || wb_inc_cur_ptr !== 1'b0) begin
      errors++; $display("FAIL drain_hold got w%b inc%b want w1 inc0", pmem_write, wb_inc_cur_ptr);
    end
    pmem_resp = 1'b1;
    tick();
    checks++; if (wb_inc_cur_ptr !== 1'b1 || pmem_write !== 1'b0 || drain_busy !== 1'b1) begin
      errors++; $display("FAIL retire got inc%b w%b busy%b want 1 0 1", wb_inc_cur_ptr, pmem_write, drain_busy);
    end
    pmem_resp = 1'b0; wb_waiting = 1'b0;
    tick();
    checks++; if (wb_inc_cur_ptr !== 1'b0 || drain_busy !== 1'b0) begin
      errors++; $display("FAIL retire_one_cycle got inc%b busy%b want 0 0", wb_inc_cur_ptr, drain_busy);
    end
    tick();
    checks++; if (pmem_write !== 1'b0) begin
      errors++; $display("FAIL drain_no_repeat got w%b want 0", pmem_write);
    end
  endtask

  task automatic test_fetch_starvation();
    wb_waiting = 1'b1; wb_full = 1'b0; wb_tag = 11'h2AA; wb_line = LC;
    fetch_req = 1'b1; fetch_addr = 16'h1234;
    tick();
    checks++; if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 16'h1220) begin
      errors++; $display("FAIL fetch1_start got r%b w%b addr %h want r1 w0 1220", pmem_read, pmem_write, pmem_address);
    end
    tick();
    checks++; if (pmem_read !== 1'b1 || fetch_resp !== 1'b0 || drain_busy !== 1'b0) begin
      errors++; $display("FAIL fetch1_hold got r%b resp%b busy%b want 1 0 0", pmem_read, fetch_resp, drain_busy);
    end
    pmem_rdata = RD1; pmem_resp = 1'b1; #1;
    checks++; if (fetch_resp !== 1'b1 || fetch_rdata !== RD1) begin
      errors++; $display("FAIL fetch1_resp got resp%b rdata %h", fetch_resp, fetch_rdata);
    end
    tick();
    pmem_resp = 1'b0; fetch_addr = 16'h5678; #1;
    checks++; if (fetch_resp !== 1'b0 || pmem_read !== 1'b0) begin
      errors++; $display("FAIL fetch1_done got resp%b r%b want 0 0", fetch_resp, pmem_read);
    end
    tick();
    checks++; if (pmem_read !== 1'b1 || pmem_address !== 16'h5660) begin
      errors++; $display("FAIL fetch2_grant got r%b addr %h want r1 5660", pmem_read, pmem_address);
    end
    pmem_rdata = RD2; pmem_resp = 1'b1; #1;
    checks++; if (fetch_resp !== 1'b1 || fetch_rdata !== RD2) begin
      errors++; $display("FAIL fetch2_resp got resp%b rdata %h", fetch_resp, fetch_rdata);
    end
    tick();
    pmem_resp = 1'b0; fetch_addr = 16'h9ABC;
    tick();
    checks++; if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 16'h5540 || drain_tag !== 11'h2AA) begin
      errors++; $display("FAIL starve_drain got w%b r%b addr %h tag %h want w1 r0 5540 2aa",
                         pmem_write, pmem_read, pmem_address, drain_tag);
    end
    pmem_resp = 1'b1;
    tick();
    checks++; if (wb_inc_cur_ptr !== 1'b1 || fetch_resp !== 1'b0) begin
      errors++; $display("FAIL starve_retire got inc%b resp%b want 1 0", wb_inc_cur_ptr, fetch_resp);
    end
    pmem_resp = 1'b0; wb_tag = 11'h0F0; wb_line = LD;
    tick();
    tick();
    checks++; if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 16'h9AA0) begin
      errors++; $display("FAIL streak_cleared got r%b w%b addr %h want r1 w0 9aa0", pmem_read, pmem_write, pmem_address);
    end
    pmem_rdata = RD3; pmem_resp = 1'b1; #1;
    checks++; if (fetch_resp !== 1'b1 || fetch_rdata !== RD3) begin
      errors++; $display("FAIL fetch3_resp got resp%b rdata %h", fetch_resp, fetch_rdata);
    end
    tick();
    pmem_resp = 1'b0; fetch_req = 1'b0;
    tick();
    checks++; if (pmem_write !== 1'b1 || pmem_address !== 16'h1E00 || pmem_wdata !== LD) begin
      errors++; $display("FAIL idle_drain got w%b addr %h want w1 1e00", pmem_write, pmem_address);
    end
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0; wb_waiting = 1'b0;
    tick();
  endtask

  task automatic test_full_override();
    wb_full = 1'b1; wb_waiting = 1'b1; wb_tag = 11'h321; wb_line = LE;
    fetch_req = 1'b1; fetch_addr = 16'hABCD;
    tick();
    checks++; if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 16'h6420) begin
      errors++; $display("FAIL full_drain got w%b r%b addr %h want w1 r0 6420", pmem_write, pmem_read, pmem_address);
    end
    pmem_resp = 1'b1; #1;
    checks++; if (fetch_resp !== 1'b0) begin
      errors++; $display("FAIL full_no_early_resp got resp%b want 0", fetch_resp);
    end
    tick();
    checks++; if (wb_inc_cur_ptr !== 1'b1 || fetch_resp !== 1'b0) begin
      errors++; $display("FAIL full_retire got inc%b resp%b want 1 0", wb_inc_cur_ptr, fetch_resp);
    end
    pmem_resp = 1'b0; wb_waiting = 1'b0; wb_full = 1'b0;
    tick();
    checks++; if (pmem_read !== 1'b0 || wb_inc_cur_ptr !== 1'b0) begin
      errors++; $display("FAIL full_idle got r%b inc%b want 0 0", pmem_read, wb_inc_cur_ptr);
    end
    tick();
    checks++; if (pmem_read !== 1'b1 || pmem_address !== 16'hABC0) begin
      errors++; $display("FAIL full_fetch got r%b addr %h want r1 abc0", pmem_read, pmem_address);
    end
    pmem_rdata = RD4; pmem_resp = 1'b1; #1;
    checks++; if (fetch_resp !== 1'b1 || fetch_rdata !== RD4) begin
      errors++; $display("FAIL full_fetch_resp got resp%b rdata %h", fetch_resp, fetch_rdata);
    end
    tick();
    pmem_resp = 1'b0; fetch_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_drain();
    int n0;
    n0 = inc_count;
    wb_waiting = 1'b1; wb_tag = 11'h3C5; wb_line = LF; fetch_req = 1'b0;
    tick();
    tick();
    checks++; if (pmem_write !== 1'b1) begin
      errors++; $display("FAIL mid_drain_active got w%b want 1", pmem_write);
    end
    reset = 1'b1; #1;
    checks++; if (pmem_write !== 1'b0 || drain_busy !== 1'b0 || pmem_address !== 16'h0000) begin
      errors++; $display("FAIL reset_drops got w%b busy%b addr %h want 0 0 0000", pmem_write, drain_busy, pmem_address);
    end
    tick();
    reset = 1'b0;
    tick();
    checks++; if (pmem_write !== 1'b1 || pmem_address !== 16'h78A0 || pmem_wdata !== LF || drain_tag !== 11'h3C5) begin
      errors++; $display("FAIL redrain got w%b addr %h tag %h want w1 78a0 3c5", pmem_write, pmem_address, drain_tag);
    end
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0; wb_waiting = 1'b0;
    tick();
    checks++; if (inc_count - n0 !== 1) begin
      errors++; $display("FAIL reset_inc_count got %0d want 1", inc_count - n0);
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = inc_count; inc_last = -100; inc_min_gap = 1000;
    wb_waiting = 1'b1; wb_tag = 11'h001; wb_line = LA; fetch_req = 1'b0;
    tick();
    checks++; if (pmem_write !== 1'b1 || pmem_address !== 16'h0020) begin
      errors++; $display("FAIL b2b_first got w%b addr %h want w1 0020", pmem_write, pmem_address);
    end
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0; wb_tag = 11'h7FF; wb_line = LB;
    tick();
    checks++; if (pmem_write !== 1'b0) begin
      errors++; $display("FAIL b2b_gap got w%b want 0", pmem_write);
    end
    tick();
    checks++; if (pmem_write !== 1'b1 || pmem_address !== 16'hFFE0 || pmem_wdata !== LB) begin
      errors++; $display("FAIL b2b_second got w%b addr %h want w1 ffe0", pmem_write, pmem_address);
    end
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0; wb_waiting = 1'b0;
    tick();
    tick();
    checks++; if (inc_count - n0 !== 2) begin
      errors++; $display("FAIL b2b_inc_count got %0d want 2", inc_count - n0);
    end
    checks++; if (inc_min_gap < 3) begin
      errors++; $display("FAIL b2b_inc_spacing got %0d want >=3", inc_min_gap);
    end
  endtask

  task automatic test_exclusive();
    checks++; if (excl_viol !== 0) begin
      errors++; $display("FAIL exclusive_strobes got %0d overlaps want 0", excl_viol);
    end
  endtask

  initial begin
    test_reset();
    test_single_drain();
    test_fetch_starvation();
    test_full_override();
    test_reset_mid_drain();
    test_back_to_back();
    test_exclusive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
